// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch/redirect controller: state encoding,
// datapath widths and the default bubble instruction.
package fetch_redirect_ctrl_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0]    PC_INC        = 16'd2;
    localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Instruction-memory request/response handshake between fetch (master) and the
// memory or cache (slave).
interface fetch_redirect_ctrl_if;
    import fetch_redirect_ctrl_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_redirect_ctrl_if_id.sv
// IF/ID pipeline register: flush has priority over load; with neither asserted
// the contents are held (decode stall or fetch still in progress).
module fetch_redirect_ctrl_if_id
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc_plus2,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc_plus2
);

    // NOTE: state is written with non-blocking assignments so every flop samples
    // pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
        end else if (flush) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc_plus2 <= load_pc_plus2;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-side PC, instruction-memory handshake and IF/ID control. Handles misses
// with redirects arriving mid-miss, decode stalls via a one-entry skid, and halt.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_in,
    input  logic                   redir_valid,
    input  logic [PC_W-1:0]        redir_target,
    input  logic                   halt_in,
    fetch_redirect_ctrl_if.master  imem,
    output logic                   if_valid,
    output logic [INSTR_W-1:0]     if_instr,
    output logic [PC_W-1:0]        if_pc_plus2,
    output logic                   flush_id,
    output logic                   halted
);

    fetch_state_e       state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus2;
    logic [PC_W-1:0]    saved_target;
    logic [INSTR_W-1:0] skid;
    logic               drop_pending;
    logic               halt_pending;
    logic               redir_acc;
    logic               req;
    logic               ifid_load;
    logic               ifid_flush;
    logic [INSTR_W-1:0] ifid_instr;

    assign redir_acc = redir_valid & ~stall_in & ~halt_in;
    assign pc_plus2  = pc + PC_INC;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        req = 1'b0;
        case (state)
            ST_FETCH: req = ~stall_in & ~redir_acc & ~halt_in;
            ST_WAIT:  req = 1'b1;
            default:  req = 1'b0;
        endcase
    end

    // Gated with rst_n so the request drops the instant reset asserts.
    assign imem.imem_req  = rst_n & req;
    assign imem.imem_addr = pc;
    assign flush_id       = redir_acc & (state != ST_HALTED);
    assign halted         = (state == ST_HALTED);

    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_instr = imem.imem_rdata;
        case (state)
            ST_FETCH: begin
                if (halt_in || redir_acc) ifid_flush = 1'b1;
                else if (req) begin
                    if (imem.imem_ready) ifid_load  = 1'b1;
                    else                 ifid_flush = 1'b1;
                end
            end
            ST_WAIT: begin
                if (halt_in || redir_acc) ifid_flush = 1'b1;
                else if (imem.imem_ready && !drop_pending && !halt_pending && !stall_in)
                    ifid_load = 1'b1;
            end
            ST_HOLD: begin
                if (halt_in) ifid_flush = 1'b1;
                else if (!stall_in) begin
                    if (redir_acc) ifid_flush = 1'b1;
                    else begin
                        ifid_load  = 1'b1;
                        ifid_instr = skid;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            saved_target <= '0;
            skid         <= '0;
            drop_pending <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (halt_in)        state <= ST_HALTED;
                    else if (redir_acc) pc    <= redir_target;
                    else if (req) begin
                        if (imem.imem_ready) pc    <= pc_plus2;
                        else                 state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_ready) begin
                        drop_pending <= 1'b0;
                        halt_pending <= 1'b0;
                        // A redirect landing with the data still wins: the data is stale.
                        if (drop_pending || redir_acc) begin
                            pc    <= redir_acc ? redir_target : saved_target;
                            state <= ST_FETCH;
                        end else if (halt_pending || halt_in) begin
                            state <= ST_HALTED;
                        end else if (stall_in) begin
                            skid  <= imem.imem_rdata;
                            state <= ST_HOLD;
                        end else begin
                            pc    <= pc_plus2;
                            state <= ST_FETCH;
                        end
                    end else if (halt_in) begin
                        halt_pending <= 1'b1;
                    end else if (redir_acc) begin
                        drop_pending <= 1'b1;
                        saved_target <= redir_target;
                    end
                end
                ST_HOLD: begin
                    if (halt_in) state <= ST_HALTED;
                    else if (!stall_in) begin
                        pc    <= redir_acc ? redir_target : pc_plus2;
                        state <= ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_redirect_ctrl_if_id #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (ifid_load),
        .flush         (ifid_flush),
        .load_instr    (ifid_instr),
        .load_pc_plus2 (pc_plus2),
        .valid         (if_valid),
        .instr         (if_instr),
        .pc_plus2      (if_pc_plus2)
    );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: hit stream, redirects on hit and
// mid-miss, stall into the skid, halt priority, PC wrap and async reset.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_in = 1'b0;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_target = '0;
    logic        halt_in = 1'b0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        flush_id;
    logic        halted;

    int errors = 0;
    int checks = 0;

    fetch_redirect_ctrl_if imem ();

    fetch_redirect_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_in     (stall_in),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .halt_in      (halt_in),
        .imem         (imem),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc_plus2  (if_pc_plus2),
        .flush_id     (flush_id),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        return a ^ 16'h5A00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        stall_in = 1'b0; redir_valid = 1'b0; redir_target = '0; halt_in = 1'b0;
        imem.imem_ready = 1'b0; imem.imem_rdata = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall_in = 1'b0; redir_valid = 1'b0; halt_in = 1'b0;
        imem.imem_ready = 1'b0; imem.imem_rdata = '0;
        step();
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem.imem_req); end
        checks++; if (imem.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", imem.imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== 16'h0800) begin errors++; $display("FAIL reset_instr: got %h want 0800", if_instr); end
        checks++; if (if_pc_plus2 !== 16'h0000) begin errors++; $display("FAIL reset_pcp2: got %h want 0000", if_pc_plus2); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_hit_stream();
        imem.imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] a;
            a = 16'(2 * i);
            imem.imem_rdata = word(a);
            #1;
            checks++; if (imem.imem_addr !== a) begin errors++; $display("FAIL hit_addr[%0d]: got %h want %h", i, imem.imem_addr, a); end
            checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL hit_req[%0d]: got %b want 1", i, imem.imem_req); end
            if (i > 0) begin
                checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL hit_valid[%0d]: got %b want 1", i, if_valid); end
                checks++; if (if_pc_plus2 !== a) begin errors++; $display("FAIL hit_pcp2[%0d]: got %h want %h", i, if_pc_plus2, a); end
                checks++; if (if_instr !== word(a - 16'd2)) begin errors++; $display("FAIL hit_instr[%0d]: got %h want %h", i, if_instr, word(a - 16'd2)); end
            end else begin
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hit_valid0: got %b want 0", if_valid); end
            end
            step();
        end
        checks++; if (if_pc_plus2 !== 16'h0008) begin errors++; $display("FAIL hit_pcp2_last: got %h want 0008", if_pc_plus2); end
    endtask

    task automatic test_redirect_hit();
        apply_reset();
        imem.imem_ready = 1'b1;
        imem.imem_rdata = word(16'h0000); step();
        imem.imem_rdata = word(16'h0002); step();
        redir_valid = 1'b1; redir_target = 16'h0040; imem.imem_rdata = word(16'h0004);
        #1;
        checks++; if (imem.imem_addr !== 16'h0004) begin errors++; $display("FAIL rh_addr_before: got %h want 0004", imem.imem_addr); end
        checks++; if (flush_id !== 1'b1) begin errors++; $display("FAIL rh_flush: got %b want 1", flush_id); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rh_req: got %b want 0", imem.imem_req); end
        step();
        redir_valid = 1'b0; imem.imem_rdata = word(16'h0040);
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b want 0", if_valid); end
        checks++; if (imem.imem_addr !== 16'h0040) begin errors++; $display("FAIL rh_addr: got %h want 0040", imem.imem_addr); end
        checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL rh_flush_clr: got %b want 0", flush_id); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc_plus2 !== 16'h0042 || if_instr !== word(16'h0040)) begin
            errors++; $display("FAIL rh_after: got v=%b pcp2=%h instr=%h want v=1 pcp2=0042 instr=%h", if_valid, if_pc_plus2, if_instr, word(16'h0040)); end
    endtask

    task automatic test_redirect_miss();
        redir_valid = 1'b1; redir_target = 16'h0008; imem.imem_ready = 1'b1;
        step();
        redir_valid = 1'b0; imem.imem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin redir_valid = 1'b1; redir_target = 16'h0100; end
            #1;
            checks++; if (imem.imem_addr !== 16'h0008 || imem.imem_req !== 1'b1) begin
                errors++; $display("FAIL rm_hold[%0d]: got addr=%h req=%b want addr=0008 req=1", c, imem.imem_addr, imem.imem_req); end
            if (c == 2) begin
                checks++; if (flush_id !== 1'b1) begin errors++; $display("FAIL rm_flush: got %b want 1", flush_id); end
            end
            step();
            redir_valid = 1'b0;
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rm_valid[%0d]: got %b want 0", c, if_valid); end
        end
        imem.imem_ready = 1'b1; imem.imem_rdata = word(16'h0008);
        #1;
        checks++; if (imem.imem_addr !== 16'h0008 || imem.imem_req !== 1'b1) begin
            errors++; $display("FAIL rm_ready: got addr=%h req=%b want addr=0008 req=1", imem.imem_addr, imem.imem_req); end
        step();
        imem.imem_rdata = word(16'h0100);
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rm_discard: got %b want 0", if_valid); end
        checks++; if (imem.imem_addr !== 16'h0100 || imem.imem_req !== 1'b1) begin
            errors++; $display("FAIL rm_next: got addr=%h req=%b want addr=0100 req=1", imem.imem_addr, imem.imem_req); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc_plus2 !== 16'h0102) begin
            errors++; $display("FAIL rm_fetch: got v=%b pcp2=%h want v=1 pcp2=0102", if_valid, if_pc_plus2); end
    endtask

    task automatic test_stall_miss();
        redir_valid = 1'b1; redir_target = 16'h0010; imem.imem_ready = 1'b1;
        step();
        redir_valid = 1'b0; imem.imem_ready = 1'b0;
        step();
        imem.imem_ready = 1'b1; imem.imem_rdata = 16'hA5A5; stall_in = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0010) begin
            errors++; $display("FAIL sm_wait: got req=%b addr=%h want req=1 addr=0010", imem.imem_req, imem.imem_addr); end
        step();
        imem.imem_ready = 1'b0; imem.imem_rdata = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) stall_in = 1'b0;
            #1;
            checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL sm_hold_req[%0d]: got %b want 0", c, imem.imem_req); end
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL sm_hold_valid[%0d]: got %b want 0", c, if_valid); end
            step();
        end
        checks++; if (if_valid !== 1'b1 || if_instr !== 16'hA5A5 || if_pc_plus2 !== 16'h0012) begin
            errors++; $display("FAIL sm_release: got v=%b instr=%h pcp2=%h want v=1 instr=a5a5 pcp2=0012", if_valid, if_instr, if_pc_plus2); end
        checks++; if (imem.imem_addr !== 16'h0012) begin errors++; $display("FAIL sm_addr: got %h want 0012", imem.imem_addr); end
    endtask

    task automatic test_wrap();
        redir_valid = 1'b1; redir_target = 16'hFFFE; imem.imem_ready = 1'b1;
        step();
        redir_valid = 1'b0; imem.imem_rdata = word(16'hFFFE);
        #1;
        checks++; if (imem.imem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr: got %h want fffe", imem.imem_addr); end
        step();
        checks++; if (if_pc_plus2 !== 16'h0000 || if_valid !== 1'b1 || if_instr !== word(16'hFFFE)) begin
            errors++; $display("FAIL wrap_ifid: got v=%b pcp2=%h instr=%h want v=1 pcp2=0000 instr=%h", if_valid, if_pc_plus2, if_instr, word(16'hFFFE)); end
        checks++; if (imem.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next: got %h want 0000", imem.imem_addr); end
    endtask

    task automatic test_halt_vs_redirect();
        halt_in = 1'b1; redir_valid = 1'b1; redir_target = 16'h0200;
        #1;
        checks++; if (flush_id !== 1'b0 || imem.imem_req !== 1'b0) begin
            errors++; $display("FAIL halt_cycle: got flush=%b req=%b want 0 0", flush_id, imem.imem_req); end
        step();
        halt_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            redir_valid = c[0]; redir_target = 16'h0300;
            #1;
            checks++; if (halted !== 1'b1 || imem.imem_req !== 1'b0 || if_valid !== 1'b0 || flush_id !== 1'b0 || imem.imem_addr !== 16'h0000) begin
                errors++; $display("FAIL halted[%0d]: got h=%b req=%b v=%b fl=%b addr=%h want 1 0 0 0 0000", c, halted, imem.imem_req, if_valid, flush_id, imem.imem_addr); end
            step();
        end
        redir_valid = 1'b0;
    endtask

    task automatic test_async_reset_wait();
        apply_reset();
        imem.imem_ready = 1'b1; imem.imem_rdata = word(16'h0000);
        step();
        imem.imem_ready = 1'b0;
        step();
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0002) begin
            errors++; $display("FAIL ar_wait: got req=%b addr=%h want req=1 addr=0002", imem.imem_req, imem.imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b want 0", imem.imem_req); end
        checks++; if (imem.imem_addr !== 16'h0000) begin errors++; $display("FAIL ar_pc: got %h want 0000", imem.imem_addr); end
        checks++; if (if_valid !== 1'b0 || if_instr !== 16'h0800) begin
            errors++; $display("FAIL ar_ifid: got v=%b instr=%h want v=0 instr=0800", if_valid, if_instr); end
        step();
        rst_n = 1'b1;
        imem.imem_ready = 1'b1; imem.imem_rdata = word(16'h0000);
        #1;
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0000 || halted !== 1'b0) begin
            errors++; $display("FAIL ar_restart: got req=%b addr=%h h=%b want 1 0000 0", imem.imem_req, imem.imem_addr, halted); end
    endtask

    initial begin
        test_reset();
        test_hit_stream();
        test_redirect_hit();
        test_redirect_miss();
        test_stall_miss();
        test_wrap();
        test_halt_vs_redirect();
        test_async_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
